poly_mod_sqr_iter: RTL and testbench

Iterated modular squaring/multiplication engine for the VDF datapath. Each of NUM_CH channels computes x^(2^T) mod MODULUS (square mode) or x·b^T mod MODULUS (multiply mode), starting from a loaded value.
The block feeds results back around one shared, fixed-latency pipelined polynomial modular multiplier. Channels are time-division interleaved into the multiplier's pipeline slots.
Values stay in redundant polynomial form (I_WORD coefficients of COEF_BITS) end to end.

---
 rtl/poly_mod_pkg.sv | 27 ++
 rtl/poly_mod_sqr_iter_mult.sv | 101 ++++++++++
 rtl/poly_mod_sqr_iter.sv | 198 +++++++++++++++++++
 tb/tb_poly_mod_sqr_iter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_mod_pkg.sv
// Shared definitions for the iterated modular squaring engine.
//   ch_state_e      : per-channel sequencer state
//   calc_i_word     : coefficient count of a redundant value (NUM_WORDS+1)
//   calc_coef_bits  : bits per redundant coefficient
//   calc_ch_bits    : index width for N items, never below 1
package poly_mod_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ch_state_e;

   function automatic int unsigned calc_i_word(input int unsigned num_words);
      return num_words + 1;
   endfunction

   function automatic int unsigned calc_coef_bits(input int unsigned word_bits,
                                                  input int unsigned redun_bits);
      return word_bits + redun_bits;
   endfunction

   function automatic int unsigned calc_ch_bits(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/poly_mod_sqr_iter_mult.sv
// poly_mod_mult: fixed-latency pipelined modular multiplier on redundant
// polynomial operands.
//   i_clk, i_rst : clock, synchronous active-high reset (clears valids)
//   i_val        : operands present this cycle
//   i_dat_a/b    : operands, I_WORD coefficients of COEF_BITS each
//                  (i_dat_b ignored when SQ_MODE=1, a*a is formed)
//   o_val, o_dat : product mod MODULUS exactly LATENCY cycles after i_val,
//                  emitted with zero redundant bits
module poly_mod_mult
   import poly_mod_pkg::*;
#(
   parameter int unsigned SQ_MODE         = 1,
   parameter int unsigned WORD_BITS       = 8,
   parameter int unsigned NUM_WORDS       = 4,
   parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = 128,
   parameter int unsigned REDUCTION_BITS  = 9,
   parameter int unsigned REDUN_WORD_BITS = 1,
   parameter int unsigned LATENCY         = 6,
   localparam int unsigned I_WORD    = calc_i_word(NUM_WORDS),
   localparam int unsigned COEF_BITS = calc_coef_bits(WORD_BITS, REDUN_WORD_BITS),
   localparam int unsigned DW        = I_WORD * COEF_BITS
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_val,
   input  logic [DW-1:0] i_dat_a,
   input  logic [DW-1:0] i_dat_b,
   output logic          o_val,
   output logic [DW-1:0] o_dat
);

   localparam int unsigned MW = WORD_BITS * NUM_WORDS;
   // Redundant value is below 2^(MW+COEF_BITS+1).
   localparam int unsigned VW = MW + COEF_BITS + 1;
   localparam int unsigned PW = 2 * VW;

   if (LATENCY < 2) begin : g_lat_chk
      $error("poly_mod_mult: LATENCY must be at least 2");
   end
   if (REDUCTION_BITS == 0) begin : g_red_chk
      $error("poly_mod_mult: REDUCTION_BITS must be non-zero");
   end

   function automatic logic [VW-1:0] to_int(input logic [DW-1:0] d);
      logic [VW-1:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < I_WORD; i++) begin
         acc = acc + (VW'(d[i*COEF_BITS +: COEF_BITS]) << (WORD_BITS * i));
      end
      return acc;
   endfunction

   function automatic logic [DW-1:0] to_red(input logic [MW-1:0] v);
      logic [DW-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         r[i*COEF_BITS +: WORD_BITS] = v[i*WORD_BITS +: WORD_BITS];
      end
      return r;
   endfunction

   logic          in_vld_q;
   logic [DW-1:0] a_q, b_q;
   logic [DW-1:0] op_b;
   logic [DW-1:0] res_dat;

   logic [LATENCY-2:0] vld_q;
   logic [DW-1:0]      dat_q [LATENCY-1];

   assign op_b = (SQ_MODE != 0) ? a_q : b_q;

   always_comb begin
      res_dat = to_red(MW'((PW'(to_int(a_q)) * PW'(to_int(op_b))) % PW'(MODULUS)));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         in_vld_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         vld_q    <= '0;
         for (int unsigned k = 0; k < LATENCY - 1; k++) begin
            dat_q[k] <= '0;
         end
      end else begin
         in_vld_q <= i_val;
         a_q      <= i_dat_a;
         b_q      <= i_dat_b;
         vld_q[0] <= in_vld_q;
         dat_q[0] <= res_dat;
         for (int unsigned k = 1; k < LATENCY - 1; k++) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= dat_q[k-1];
         end
      end
   end

   assign o_val = vld_q[LATENCY-2];
   assign o_dat = dat_q[LATENCY-2];

endmodule

// File: rtl/poly_mod_sqr_iter.sv
// poly_mod_sqr_iter: NUM_CH channels iterate x <- x*x (or x*b) mod MODULUS
// T times around one shared pipelined multiplier, time-division interleaved
// by a free-running slot counter (channel c owns slot c).
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_val, i_ch, o_rdy    : load request for channel i_ch, accepted when IDLE
//   i_dat_a, i_dat_b      : initial x, base b (b used only when SQ_MODE=0)
//   i_iter                : iteration count T (T=0 returns x unchanged)
//   o_val, o_ch, o_dat    : lowest DONE channel's result, held under backpressure
//   i_rdy                 : downstream accepts the presented result
//   o_busy                : per-channel not-IDLE flags
module poly_mod_sqr_iter
   import poly_mod_pkg::*;
#(
   parameter int unsigned SQ_MODE         = 1,
   parameter int unsigned WORD_BITS       = 8,
   parameter int unsigned NUM_WORDS       = 4,
   parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = 128,
   parameter int unsigned REDUCTION_BITS  = 9,
   parameter int unsigned REDUN_WORD_BITS = 1,
   parameter int unsigned MUL_LAT         = 6,
   parameter int unsigned NUM_CH          = 2,
   parameter int unsigned ITER_BITS       = 32,
   localparam int unsigned I_WORD    = calc_i_word(NUM_WORDS),
   localparam int unsigned COEF_BITS = calc_coef_bits(WORD_BITS, REDUN_WORD_BITS),
   localparam int unsigned CH_BITS   = calc_ch_bits(NUM_CH)
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_val,
   output logic                        o_rdy,
   input  logic [CH_BITS-1:0]          i_ch,
   input  logic [I_WORD*COEF_BITS-1:0] i_dat_a,
   input  logic [I_WORD*COEF_BITS-1:0] i_dat_b,
   input  logic [ITER_BITS-1:0]        i_iter,
   output logic                        o_val,
   input  logic                        i_rdy,
   output logic [CH_BITS-1:0]          o_ch,
   output logic [I_WORD*COEF_BITS-1:0] o_dat,
   output logic [NUM_CH-1:0]           o_busy
);

   localparam int unsigned DW        = I_WORD * COEF_BITS;
   localparam int unsigned SLOT_BITS = calc_ch_bits(MUL_LAT);

   if (NUM_CH < 1 || NUM_CH > MUL_LAT) begin : g_ch_chk
      $error("poly_mod_sqr_iter: NUM_CH must be in 1..MUL_LAT");
   end
   if (MUL_LAT < 2) begin : g_lat_chk
      $error("poly_mod_sqr_iter: MUL_LAT must be at least 2");
   end

   typedef struct packed {
      ch_state_e            state;
      logic [DW-1:0]        x;
      logic [DW-1:0]        b;
      logic [ITER_BITS-1:0] rem;
      logic                 infl;
   } ch_ctx_t;

   localparam ch_ctx_t CTX_RESET = '{state: ST_IDLE, x: '0, b: '0, rem: '0, infl: 1'b0};

   ch_ctx_t              ctx_q [NUM_CH];
   ch_ctx_t              ctx_d [NUM_CH];
   logic [SLOT_BITS-1:0] slot_q, slot_d;
   logic                 lock_q, lock_d;
   logic [CH_BITS-1:0]   lock_ch_q, lock_ch_d;

   logic                 mul_val;
   logic [DW-1:0]        mul_a, mul_b;
   logic                 mul_o_val;
   logic [DW-1:0]        mul_o_dat;

   logic                 done_any;
   logic [CH_BITS-1:0]   low_ch;
   logic [CH_BITS-1:0]   sel_ch;
   logic                 hs;

   poly_mod_mult #(
      .SQ_MODE         ((SQ_MODE == 0) ? 0 : 1),
      .WORD_BITS       (WORD_BITS),
      .NUM_WORDS       (NUM_WORDS),
      .MODULUS         (MODULUS),
      .REDUCTION_BITS  (REDUCTION_BITS),
      .REDUN_WORD_BITS (REDUN_WORD_BITS),
      .LATENCY         (MUL_LAT)
   ) u_mult (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_val   (mul_val),
      .i_dat_a (mul_a),
      .i_dat_b (mul_b),
      .o_val   (mul_o_val),
      .o_dat   (mul_o_dat)
   );

   // Output arbiter. A presented-but-unaccepted channel stays locked so a
   // lower channel finishing later cannot preempt it.
   always_comb begin
      done_any = 1'b0;
      low_ch   = '0;
      for (int unsigned c = NUM_CH; c > 0; c--) begin
         if (ctx_q[c-1].state == ST_DONE) begin
            done_any = 1'b1;
            low_ch   = CH_BITS'(c - 1);
         end
      end
      sel_ch = lock_q ? lock_ch_q : low_ch;

      o_val = done_any;
      o_ch  = '0;
      o_dat = '0;
      if (done_any) begin
         o_ch = sel_ch;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (CH_BITS'(c) == sel_ch) o_dat = ctx_q[c].x;
         end
      end

      o_rdy  = 1'b0;
      o_busy = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (CH_BITS'(c) == i_ch) o_rdy = (ctx_q[c].state == ST_IDLE);
         o_busy[c] = (ctx_q[c].state != ST_IDLE);
      end
   end

   assign hs        = o_val & i_rdy;
   assign lock_d    = o_val & ~i_rdy;
   assign lock_ch_d = o_ch;

   // Sequencer. On a returning product with iterations left, the product is
   // fed straight back into the multiplier in the same slot, so infl stays set.
   always_comb begin
      ctx_d   = ctx_q;
      mul_val = 1'b0;
      mul_a   = '0;
      mul_b   = '0;
      slot_d  = (slot_q == SLOT_BITS'(MUL_LAT - 1)) ? '0 : slot_q + SLOT_BITS'(1);

      for (int unsigned c = 0; c < NUM_CH; c++) begin
         unique case (ctx_q[c].state)
            ST_IDLE: begin
               if (i_val && (i_ch == CH_BITS'(c))) begin
                  ctx_d[c].x     = i_dat_a;
                  ctx_d[c].b     = i_dat_b;
                  ctx_d[c].rem   = i_iter;
                  ctx_d[c].infl  = 1'b0;
                  ctx_d[c].state = (i_iter == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (slot_q == SLOT_BITS'(c)) begin
                  if (!ctx_q[c].infl) begin
                     mul_val       = 1'b1;
                     mul_a         = ctx_q[c].x;
                     mul_b         = ctx_q[c].b;
                     ctx_d[c].infl = 1'b1;
                  end else if (mul_o_val) begin
                     ctx_d[c].rem = ctx_q[c].rem - ITER_BITS'(1);
                     ctx_d[c].x   = mul_o_dat;
                     if (ctx_q[c].rem == ITER_BITS'(1)) begin
                        ctx_d[c].infl  = 1'b0;
                        ctx_d[c].state = ST_DONE;
                     end else begin
                        mul_val = 1'b1;
                        mul_a   = mul_o_dat;
                        mul_b   = ctx_q[c].b;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (hs && (o_ch == CH_BITS'(c))) ctx_d[c].state = ST_IDLE;
            end
            default: ctx_d[c] = CTX_RESET;
         endcase
      end

      if (SQ_MODE != 0) mul_b = mul_a;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         slot_q    <= '0;
         lock_q    <= 1'b0;
         lock_ch_q <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            ctx_q[c] <= CTX_RESET;
         end
      end else begin
         slot_q    <= slot_d;
         lock_q    <= lock_d;
         lock_ch_q <= lock_ch_d;
         ctx_q     <= ctx_d;
      end
   end

endmodule

// File: tb/tb_poly_mod_sqr_iter.sv
module tb_poly_mod_sqr_iter;

   localparam longint M   = 1000003;
   localparam int     LAT = 6;
   localparam int     NCH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_val, i_rdy;
   logic        i_ch;
   logic [44:0] i_dat_a, i_dat_b;
   logic [31:0] i_iter;
   logic        o_rdy, o_val, o_ch;
   logic [44:0] o_dat;
   logic [1:0]  o_busy;

   logic        mi_val;
   logic        mi_ch;
   logic [44:0] mi_dat_a, mi_dat_b;
   logic [31:0] mi_iter;
   logic        mo_rdy, mo_val, mo_ch;
   logic [44:0] mo_dat;
   logic [1:0]  mo_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   poly_mod_sqr_iter #(
      .SQ_MODE(1), .WORD_BITS(8), .NUM_WORDS(4), .MODULUS(32'd1000003),
      .REDUCTION_BITS(9), .REDUN_WORD_BITS(1), .MUL_LAT(LAT), .NUM_CH(NCH), .ITER_BITS(32)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_val(i_val), .o_rdy(o_rdy), .i_ch(i_ch),
      .i_dat_a(i_dat_a), .i_dat_b(i_dat_b), .i_iter(i_iter), .o_val(o_val),
      .i_rdy(i_rdy), .o_ch(o_ch), .o_dat(o_dat), .o_busy(o_busy)
   );

   poly_mod_sqr_iter #(
      .SQ_MODE(0), .WORD_BITS(8), .NUM_WORDS(4), .MODULUS(32'd1000003),
      .REDUCTION_BITS(9), .REDUN_WORD_BITS(1), .MUL_LAT(LAT), .NUM_CH(NCH), .ITER_BITS(32)
   ) dut_mul (
      .i_clk(clk), .i_rst(rst), .i_val(mi_val), .o_rdy(mo_rdy), .i_ch(mi_ch),
      .i_dat_a(mi_dat_a), .i_dat_b(mi_dat_b), .i_iter(mi_iter), .o_val(mo_val),
      .i_rdy(1'b1), .o_ch(mo_ch), .o_dat(mo_dat), .o_busy(mo_busy)
   );

   function automatic void check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Redundant form -> integer mod M: coefficient i weighs 2^(8*i).
   function automatic longint red2int(input logic [44:0] d);
      longint v;
      v = 0;
      for (int i = 0; i < 5; i++) v += longint'(d[i*9 +: 9]) << (8 * i);
      return v % M;
   endfunction

   function automatic logic [44:0] to_red(input longint v);
      logic [44:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[i*9 +: 8] = 8'((v >> (8 * i)) & 255);
      return r;
   endfunction

   // ---------------- behavioural model + per-cycle compare ----------------
   bit          started = 0;
   bit          m_busy [NCH];
   longint      m_done [NCH];
   longint      m_res  [NCH];
   longint      n = 0;          // cycles since reset; slot = n % LAT
   bit          pres_v = 0;
   int          pres_ch = 0;
   logic [44:0] prev_dat = '0;

   always @(negedge clk) begin
      bit     ev, ld;
      int     ech;
      longint v, m;
      if (started) begin
         ev  = 0;
         ech = 0;
         for (int c = NCH - 1; c >= 0; c--) begin
            if (m_busy[c] && n >= m_done[c]) begin
               ev  = 1;
               ech = c;
            end
         end
         if (pres_v) ech = pres_ch;

         check("cmp_o_val", o_val, ev);
         check("cmp_o_busy", o_busy, {m_busy[1], m_busy[0]});
         check("cmp_o_rdy", o_rdy, !m_busy[i_ch]);
         if (ev) begin
            check("cmp_o_ch", o_ch, ech);
            check("cmp_o_dat", red2int(o_dat), m_res[ech]);
            if (pres_v) check("cmp_o_dat_hold", o_dat, prev_dat);
         end
         prev_dat = o_dat;

         if (rst) begin
            for (int c = 0; c < NCH; c++) m_busy[c] = 0;
            pres_v = 0;
            n = 0;
         end else begin
            ld = i_val && !m_busy[i_ch];
            if (ev && i_rdy) m_busy[ech] = 0;
            pres_v  = ev && !i_rdy;
            pres_ch = ech;
            if (ld) begin
               v = red2int(i_dat_a);
               for (longint k = 0; k < longint'(i_iter); k++) v = (v * v) % M;
               m_res[i_ch] = v;
               if (i_iter == 0) m_done[i_ch] = n + 1;
               else begin
                  m = n + 1;
                  while ((m % LAT) != longint'(i_ch)) m++;
                  m_done[i_ch] = m + longint'(i_iter) * LAT + 1;
               end
               m_busy[i_ch] = 1;
            end
            n++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int ch, input longint x, input int t);
      i_val   = 1'b1;
      i_ch    = 1'(ch);
      i_dat_a = to_red(x);
      i_iter  = 32'(t);
      tick();
      i_val   = 1'b0;
   endtask

   // Waits for o_val from posedge+1; leaves at posedge+1 after the handshake edge.
   task automatic wait_result(input string name, input int ch, input longint val,
                              input int budget, output int cyc);
      cyc = 1;
      @(negedge clk);
      while (!o_val && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (!o_val) check({name, "_timeout"}, 0, 1);
      else begin
         check({name, "_ch"}, o_ch, ch);
         check({name, "_val"}, red2int(o_dat), val);
      end
      tick();
   endtask

   task automatic wait_mul(input string name, input longint val, input int budget);
      int cyc;
      cyc = 1;
      @(negedge clk);
      while (!mo_val && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (!mo_val) check({name, "_timeout"}, 0, 1);
      else begin
         check({name, "_ch"}, mo_ch, 0);
         check({name, "_val"}, red2int(mo_dat), val);
      end
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int     cyc, cnt;
      logic [44:0] d0;
      rst = 1'b1; i_val = 1'b0; i_rdy = 1'b1; i_ch = 1'b0;
      i_dat_a = '0; i_dat_b = '0; i_iter = '0;
      mi_val = 1'b0; mi_ch = 1'b0; mi_dat_a = '0; mi_dat_b = '0; mi_iter = '0;
      tick();
      started = 1;
      tick();
      @(negedge clk);
      check("rst_o_val", o_val, 0);
      check("rst_o_busy", o_busy, 0);
      check("rst_o_ch", o_ch, 0);
      check("rst_o_dat", o_dat, 0);
      tick();
      rst = 1'b0;
      tick();

      // T=1 square, latency bound
      load(0, 3, 1);
      wait_result("sq3_t1", 0, 9, 30, cyc);
      check("sq3_t1_latency_ok", (cyc <= 2 * LAT + 1), 1);

      load(0, 2, 3);
      wait_result("sq2_t3", 0, 256, 40, cyc);

      // T=0 returns the loaded value the next cycle
      load(1, 5, 0);
      wait_result("t0_pass", 1, 5, 1, cyc);

      // ch1 finishes before ch0: 3^(2^2)=81, then 2^(2^5) mod M = 954414
      load(0, 2, 5);
      load(1, 3, 2);
      wait_result("pair_ch1", 1, 81, 60, cyc);
      wait_result("pair_ch0", 0, 954414, 60, cyc);

      // backpressure with both channels DONE
      i_rdy = 1'b0;
      load(0, 2, 1);
      load(1, 3, 2);
      repeat (30) tick();
      @(negedge clk);
      check("hold_busy", o_busy, 3);
      check("hold_ch", o_ch, 0);
      d0 = o_dat;
      repeat (40) begin
         @(negedge clk);
         check("hold_ch_stable", o_ch, 0);
         check("hold_dat_stable", o_dat, d0);
      end
      tick();
      i_rdy = 1'b1;
      @(negedge clk);
      check("rel0_ch", o_ch, 0);
      check("rel0_val", red2int(o_dat), 4);
      check("rel0_busy", o_busy, 3);
      tick();
      @(negedge clk);
      check("rel1_ch", o_ch, 1);
      check("rel1_val", red2int(o_dat), 81);
      check("rel1_busy", o_busy, 2);
      tick();
      @(negedge clk);
      check("rel_done_val", o_val, 0);
      check("rel_done_busy", o_busy, 0);
      tick();

      // a later-finishing lower channel must not preempt a presented result
      i_rdy = 1'b0;
      load(1, 5, 1);
      load(0, 3, 3);
      repeat (45) tick();
      @(negedge clk);
      check("nopre_busy", o_busy, 3);
      check("nopre_ch", o_ch, 1);
      check("nopre_val", red2int(o_dat), 25);
      tick();
      i_rdy = 1'b1;
      wait_result("nopre_first", 1, 25, 2, cyc);
      wait_result("nopre_second", 0, 6561, 2, cyc);

      // load to a RUN channel is refused and leaves it untouched
      load(0, 2, 3);
      tick();
      i_val = 1'b1; i_ch = 1'b0; i_dat_a = to_red(9); i_iter = 32'd1;
      @(negedge clk);
      check("busy_rdy", o_rdy, 0);
      tick();
      i_val = 1'b0;
      wait_result("busy_keep", 0, 256, 40, cyc);

      // reset mid-run abandons everything in flight
      load(0, 2, 20);
      load(1, 3, 20);
      repeat (10) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      load(0, 7, 1);
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_val) begin
            cnt++;
            check("post_rst_ch", o_ch, 0);
            check("post_rst_val", red2int(o_dat), 49);
         end
      end
      check("post_rst_count", cnt, 1);
      tick();

      // multiply mode: x*b^T
      mi_val = 1'b1; mi_ch = 1'b0; mi_dat_a = to_red(1); mi_dat_b = to_red(10); mi_iter = 32'd4;
      tick();
      mi_val = 1'b0;
      wait_mul("mul_1x10p4", 10000, 60);
      mi_val = 1'b1; mi_ch = 1'b0; mi_dat_a = to_red(3); mi_dat_b = to_red(7); mi_iter = 32'd2;
      tick();
      mi_val = 1'b0;
      wait_mul("mul_3x7p2", 147, 60);
      check("mul_idle_busy", mo_busy, 0);
      check("mul_idle_rdy", mo_rdy, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
